instruction_fetch_unit: RTL and testbench

Produces the 32-bit INSTRUCTION word that the control unit decodes. It holds the PC, runs a read handshake with instruction memory, and presents each fetched word with a one-cycle-or-longer valid window. After each instruction it computes the next PC (sequential, jump, or taken branch) from decoder flags. It sits between instruction memory and control_unit/register file in the 8-bit CPU.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/pc_next_unit.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 110 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction field ranges, fetch states, opcodes.
// Imported by the fetch unit, the next-PC unit and control_unit.
package cpu_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int DEST_MSB   = 23;
  localparam int DEST_LSB   = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 7;
  localparam int SRC2_LSB   = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // Signed word offset scaled to a byte displacement.
  function automatic logic [31:0] word_offset(input logic [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC: PC+4, plus a scaled signed offset on jump or taken beq.
// Zero latency; no flow control.
module pc_next_unit
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [7:0]  offset_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        zero_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] seq_pc;
  logic        take;

  assign seq_pc    = pc_i + PC_STEP;
  // Jump wins when both flags are set; the result is the same target either way.
  assign take      = jump_i | (branch_i & zero_i);
  assign next_pc_o = take ? (seq_pc + word_offset(offset_i)) : seq_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Holds the PC, fetches from instruction memory and issues one word at a time to control_unit.
// Fetch latency >= 1 cycle after entry; STALL holds the issued word; busy past MAX_WAIT halts.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID,
  output logic        FETCH_ERR
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]  next_pc;

  pc_next_unit u_pc_next (
    .pc_i      (pc_q),
    .offset_i  (OFFSET),
    .jump_i    (JUMP),
    .branch_i  (BRANCH),
    .zero_i    (ZERO),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      // Sampling only happens once state_q is FETCH, so the entry edge never captures data.
      ST_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_RDATA;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ISSUE: begin
        if (!STALL) begin
          pc_d    = next_pc;
          vld_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign IMEM_READ   = (state_q == ST_FETCH);
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = vld_q;
  assign FETCH_ERR   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a second instance starts at 0xFFFF_FFFC for PC wrap.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        RESET2 = 1'b0;
  logic [31:0] IMEM_RDATA = 32'd0;
  logic        IMEM_BUSYWAIT = 1'b1;
  logic        STALL = 1'b0;
  logic        JUMP = 1'b0;
  logic        BRANCH = 1'b0;
  logic        ZERO = 1'b0;
  logic [7:0]  OFFSET = 8'd0;

  logic        IMEM_READ, INSTR_VALID, FETCH_ERR;
  logic [31:0] IMEM_ADDR, PC, INSTRUCTION;
  logic        IMEM_READ2, INSTR_VALID2, FETCH_ERR2;
  logic [31:0] IMEM_ADDR2, PC2, INSTRUCTION2;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_RDATA(IMEM_RDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH), .ZERO(ZERO), .OFFSET(OFFSET),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .INSTR_VALID(INSTR_VALID), .FETCH_ERR(FETCH_ERR)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) dut_wrap (
    .CLK(CLK), .RESET(RESET2), .IMEM_RDATA(IMEM_RDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH), .ZERO(ZERO), .OFFSET(OFFSET),
    .IMEM_READ(IMEM_READ2), .IMEM_ADDR(IMEM_ADDR2), .PC(PC2), .INSTRUCTION(INSTRUCTION2),
    .INSTR_VALID(INSTR_VALID2), .FETCH_ERR(FETCH_ERR2)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Starting just after FETCH entry at exp_pc: hold busy, then deliver word.
  task automatic issue_word(input int busy, input logic [31:0] word, input logic [31:0] exp_pc);
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < busy; i++) begin
      step();
      n_cmp++;
      if (IMEM_READ !== 1'b1 || INSTR_VALID !== 1'b0 || IMEM_ADDR !== exp_pc) begin
        n_err++;
        $display("FAIL busy_wait[%0d]: read=%b valid=%b addr=%h, want read=1 valid=0 addr=%h",
                 i, IMEM_READ, INSTR_VALID, IMEM_ADDR, exp_pc);
      end
    end
    IMEM_BUSYWAIT = 1'b0;
    IMEM_RDATA    = word;
    step();
    IMEM_BUSYWAIT = 1'b1;
    n_cmp++;
    if (INSTRUCTION !== word || INSTR_VALID !== 1'b1 || IMEM_READ !== 1'b0) begin
      n_err++;
      $display("FAIL issue: instr=%h valid=%b read=%b, want instr=%h valid=1 read=0",
               INSTRUCTION, INSTR_VALID, IMEM_READ, word);
    end
  endtask

  // Leave ISSUE with the given decoder flags and check the new PC.
  task automatic retire(input logic j, input logic b, input logic z, input logic [7:0] off,
                        input logic [31:0] exp_pc);
    JUMP = j; BRANCH = b; ZERO = z; OFFSET = off;
    step();
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0; OFFSET = 8'd0;
    n_cmp++;
    if (PC !== exp_pc || IMEM_ADDR !== exp_pc || IMEM_READ !== 1'b1 || INSTR_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL next_pc: pc=%h addr=%h read=%b valid=%b, want pc=addr=%h read=1 valid=0",
               PC, IMEM_ADDR, IMEM_READ, INSTR_VALID, exp_pc);
    end
  endtask

  task automatic test_reset;
    repeat (2) step();
    n_cmp++;
    if (PC !== 32'd0 || INSTRUCTION !== 32'd0 || INSTR_VALID !== 1'b0 ||
        IMEM_READ !== 1'b0 || FETCH_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b read=%b err=%b, want all 0",
               PC, INSTRUCTION, INSTR_VALID, IMEM_READ, FETCH_ERR);
    end
    RESET = 1'b1;
    step();
    n_cmp++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDR !== 32'd0) begin
      n_err++;
      $display("FAIL first_fetch: read=%b addr=%h, want read=1 addr=0", IMEM_READ, IMEM_ADDR);
    end
    issue_word(2, 32'h0500_0400, 32'd0);
    retire(1'b0, 1'b0, 1'b0, 8'h00, 32'd4);
  endtask

  task automatic test_busy5;
    issue_word(5, 32'h0100_0203, 32'd4);
    n_cmp++;
    if (FETCH_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL busy5_err: err=%b, want 0", FETCH_ERR);
    end
    retire(1'b0, 1'b0, 1'b0, 8'h00, 32'd8);
  endtask

  task automatic test_jump;
    issue_word(0, 32'h06FE_0000, 32'd8);
    retire(1'b1, 1'b0, 1'b0, 8'hFE, 32'd4);
    issue_word(1, 32'h0701_0000, 32'd4);
    retire(1'b1, 1'b1, 1'b0, 8'h01, 32'd12);
    issue_word(0, 32'h0200_0102, 32'd12);
    retire(1'b0, 1'b0, 1'b0, 8'h00, 32'h10);
  endtask

  task automatic test_branch;
    issue_word(0, 32'h0702_0000, 32'h10);
    retire(1'b0, 1'b1, 1'b0, 8'h02, 32'h14);
    issue_word(0, 32'h06FE_0000, 32'h14);
    retire(1'b1, 1'b0, 1'b0, 8'hFE, 32'h10);
    issue_word(0, 32'h0702_0000, 32'h10);
    retire(1'b0, 1'b1, 1'b1, 8'h02, 32'h1C);
  endtask

  task automatic test_stall;
    JUMP = 1'b1; OFFSET = 8'h40;  // flags outside ISSUE must be ignored
    issue_word(1, 32'h0102_0304, 32'h1C);
    JUMP = 1'b0; OFFSET = 8'h00;
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (INSTR_VALID !== 1'b1 || PC !== 32'h1C || INSTRUCTION !== 32'h0102_0304 ||
          IMEM_READ !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b pc=%h instr=%h read=%b, want 1/0000001c/01020304/0",
                 i, INSTR_VALID, PC, INSTRUCTION, IMEM_READ);
      end
    end
    STALL = 1'b0;
    retire(1'b0, 1'b0, 1'b0, 8'h00, 32'h20);
  endtask

  task automatic test_wrap;
    RESET2 = 1'b1;
    IMEM_BUSYWAIT = 1'b1;
    step();
    n_cmp++;
    if (IMEM_READ2 !== 1'b1 || IMEM_ADDR2 !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_fetch: read=%b addr=%h, want read=1 addr=fffffffc", IMEM_READ2, IMEM_ADDR2);
    end
    IMEM_BUSYWAIT = 1'b0;
    IMEM_RDATA    = 32'h0A0B_0C0D;
    step();
    IMEM_BUSYWAIT = 1'b1;
    step();
    n_cmp++;
    if (PC2 !== 32'd0 || PC !== 32'h24) begin
      n_err++;
      $display("FAIL wrap_pc: pc_wrap=%h pc_main=%h, want 00000000 and 00000024", PC2, PC);
    end
  endtask

  task automatic test_halt;
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (FETCH_ERR !== 1'b0 || IMEM_READ !== 1'b1) begin
        n_err++;
        $display("FAIL halt_wait[%0d]: err=%b read=%b, want err=0 read=1", i, FETCH_ERR, IMEM_READ);
      end
    end
    step();
    n_cmp++;
    if (FETCH_ERR !== 1'b1 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL halt_entry: err=%b read=%b valid=%b, want err=1 read=0 valid=0",
               FETCH_ERR, IMEM_READ, INSTR_VALID);
    end
    IMEM_BUSYWAIT = 1'b0;  // memory recovering must not leave HALT
    repeat (3) step();
    n_cmp++;
    if (FETCH_ERR !== 1'b1 || IMEM_READ !== 1'b0 || PC !== 32'h24 || INSTRUCTION !== 32'h0A0B_0C0D) begin
      n_err++;
      $display("FAIL halt_frozen: err=%b read=%b pc=%h instr=%h, want 1/0/00000024/0a0b0c0d",
               FETCH_ERR, IMEM_READ, PC, INSTRUCTION);
    end
    #2 RESET = 1'b0;
    #1;
    n_cmp++;
    if (PC !== 32'd0 || INSTRUCTION !== 32'd0 || INSTR_VALID !== 1'b0 ||
        IMEM_READ !== 1'b0 || FETCH_ERR !== 1'b0 || IMEM_ADDR !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h instr=%h valid=%b read=%b err=%b addr=%h, want all 0",
               PC, INSTRUCTION, INSTR_VALID, IMEM_READ, FETCH_ERR, IMEM_ADDR);
    end
  endtask

  initial begin
    test_reset();
    test_busy5();
    test_jump();
    test_branch();
    test_stall();
    test_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
